// File: rtl/lc1602_if.sv
// Byte-stream and nibble-writer signals of the LC1602 sequencer, bundled for port lists.
// The master side is the sequencer; the slave side is its environment (upstream + writer).
interface lc1602_if;
  logic       i_valid;
  logic       i_is_data;
  logic [7:0] i_data;
  logic       o_ready;
  logic       o_enable;
  logic [7:0] o_mosi_data;
  logic       o_data_mode;
  logic       o_send_2nd_nibble;
  logic       o_with_pulse;
  logic       i_busy;
  logic       o_init_done;
  logic       o_busy;
  logic       o_error;

  modport master (
    input  i_valid, i_is_data, i_data, i_busy,
    output o_ready, o_enable, o_mosi_data, o_data_mode, o_send_2nd_nibble,
           o_with_pulse, o_init_done, o_busy, o_error
  );

  modport slave (
    output i_valid, i_is_data, i_data, i_busy,
    input  o_ready, o_enable, o_mosi_data, o_data_mode, o_send_2nd_nibble,
           o_with_pulse, o_init_done, o_busy, o_error
  );
endinterface

// File: rtl/lc1602_ctrl.sv
// HD44780 4-bit init sequencer plus byte FIFO in front of the LC1602 I2C nibble writer.
// Each write is one enable pulse; clear/home commands get their long settle delay here.
module lc1602_ctrl #(
  parameter int ONE_USEC    = 12,
  parameter int POWERUP_US  = 50000,
  parameter int FIFO_AW     = 3,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic     i_clk,
  input  logic     i_rst,
  lc1602_if.master bus
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int TW    = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_POWERUP, S_LOAD, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_DELAY, S_NEXT, S_IDLE
  } state_t;

  typedef struct packed {
    logic [7:0]  code;
    logic        snd2;
    logic [12:0] us;
  } rom_t;

  function automatic rom_t rom_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    rom_entry = '{code: 8'h30, snd2: 1'b0, us: 13'd4100};
      4'd1:    rom_entry = '{code: 8'h30, snd2: 1'b0, us: 13'd100};
      4'd2:    rom_entry = '{code: 8'h30, snd2: 1'b0, us: 13'd100};
      4'd3:    rom_entry = '{code: 8'h20, snd2: 1'b0, us: 13'd100};
      4'd4:    rom_entry = '{code: 8'h28, snd2: 1'b1, us: 13'd0};
      4'd5:    rom_entry = '{code: 8'h08, snd2: 1'b1, us: 13'd0};
      4'd6:    rom_entry = '{code: 8'h01, snd2: 1'b1, us: 13'd2000};
      4'd7:    rom_entry = '{code: 8'h06, snd2: 1'b1, us: 13'd0};
      4'd8:    rom_entry = '{code: 8'h0C, snd2: 1'b1, us: 13'd0};
      default: rom_entry = '0;
    endcase
  endfunction

  // ---------------------------------------------------------------- FIFO
  logic [8:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               full, empty, push, pop;
  logic [8:0]         head;
  logic [23:0]        head_dly;

  state_t      state_q;
  logic [23:0] dly_q, post_q;
  logic [3:0]  rom_idx_q;
  logic [TW-1:0] tmo_q;
  logic        enable_q, mode_q, snd2_q, init_done_q, error_q;
  logic [7:0]  mosi_q;
  rom_t        rom;

  assign full  = (count_q == (FIFO_AW + 1)'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.i_valid && !full;
  assign pop   = (state_q == S_LOAD) && init_done_q && !empty;
  assign head  = mem_q[rd_ptr_q];
  assign rom   = rom_entry(rom_idx_q);

  // Clear and return-home commands need the long execution delay.
  assign head_dly = (!head[8] && (head[7:0] inside {8'h01, 8'h02, 8'h03}))
                    ? 24'(2000 * ONE_USEC) : 24'd0;

  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.i_is_data, bus.i_data};
  end

  // NOTE: non-blocking assignments for all state so every register sees pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------- sequencer
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_POWERUP;
      dly_q       <= 24'(ONE_USEC * POWERUP_US);
      post_q      <= '0;
      rom_idx_q   <= '0;
      tmo_q       <= '0;
      enable_q    <= 1'b0;
      mosi_q      <= '0;
      mode_q      <= 1'b0;
      snd2_q      <= 1'b0;
      init_done_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      enable_q <= 1'b0;
      case (state_q)
        S_POWERUP: begin
          if (dly_q == '0) begin
            rom_idx_q <= '0;
            state_q   <= S_LOAD;
          end else begin
            dly_q <= dly_q - 1'b1;
          end
        end
        S_LOAD: begin
          if (!init_done_q) begin
            mosi_q <= rom.code;
            mode_q <= 1'b0;
            snd2_q <= rom.snd2;
            post_q <= 24'(rom.us * ONE_USEC);
          end else begin
            mosi_q <= head[7:0];
            mode_q <= head[8];
            snd2_q <= 1'b1;
            post_q <= head_dly;
          end
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          // The writer may still be finishing a transfer started before a reset.
          if (!bus.i_busy) begin
            enable_q <= 1'b1;
            tmo_q    <= '0;
            state_q  <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (bus.i_busy) begin
            state_q <= S_WAIT_DONE;
          end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
            error_q <= 1'b1;
            state_q <= S_WAIT_DONE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!bus.i_busy) begin
            if (post_q == '0) begin
              state_q <= S_NEXT;
            end else begin
              dly_q   <= post_q;
              state_q <= S_DELAY;
            end
          end
        end
        S_DELAY: begin
          if (dly_q == '0) state_q <= S_NEXT;
          else             dly_q   <= dly_q - 1'b1;
        end
        S_NEXT: begin
          if (!init_done_q) begin
            if (rom_idx_q == 4'd8) begin
              init_done_q <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              rom_idx_q <= rom_idx_q + 1'b1;
              state_q   <= S_LOAD;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (!empty) state_q <= S_LOAD;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ready           = !full;
  assign bus.o_enable          = enable_q;
  assign bus.o_mosi_data       = mosi_q;
  assign bus.o_data_mode       = mode_q;
  assign bus.o_send_2nd_nibble = snd2_q;
  assign bus.o_with_pulse      = 1'b1;
  assign bus.o_init_done       = init_done_q;
  assign bus.o_error           = error_q;
  assign bus.o_busy            = !init_done_q || !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_lc1602_ctrl.sv
// Directed bench for lc1602_ctrl: init sequence, FIFO ordering/backpressure, clear delay,
// ack timeout and mid-delay reset, against a simple busy model of the nibble writer.
module tb_lc1602_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lc1602_if bus ();

  lc1602_ctrl #(
    .ONE_USEC   (1),
    .POWERUP_US (20),
    .FIFO_AW    (2),
    .ACK_TIMEOUT(15)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct {
    int         cyc;
    logic [7:0] code;
    logic       mode;
    logic       snd2;
    logic       done;
  } rec_t;

  rec_t rec[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rel      = 0;
  int   err_cyc  = -1;
  int   busy_mode = 0;   // 0 = responds to enable, 1 = never busy, 2 = held busy
  int   bcnt     = 0;
  logic pend     = 1'b0;
  logic acc;

  logic [7:0] init_code [9] = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h28, 8'h08, 8'h01, 8'h06, 8'h0C};
  logic       init_snd2 [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [7:0] burst     [5] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};

  always @(posedge clk) cyc++;

  // Writer model: busy rises one cycle after an enable and stays high for five cycles.
  always @(negedge clk) begin
    if (bus.o_enable)
      rec.push_back('{cyc, bus.o_mosi_data, bus.o_data_mode, bus.o_send_2nd_nibble, bus.o_init_done});
    if (bus.o_error && err_cyc < 0) err_cyc = cyc;
    case (busy_mode)
      2: begin bus.i_busy = 1'b1; bcnt = 0; pend = 1'b0; end
      1: begin bus.i_busy = 1'b0; bcnt = 0; pend = 1'b0; end
      default: begin
        if (bcnt > 0) bcnt--;
        if (pend) begin bcnt = 5; pend = 1'b0; end
        bus.i_busy = (bcnt > 0);
        if (bus.o_enable) pend = 1'b1;
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_enables(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && rec.size() < n; i++) step();
    check(tag, 32'(rec.size() >= n), 32'd1);
  endtask

  task automatic wait_init(input int budget, input string tag);
    for (int i = 0; i < budget && !bus.o_init_done; i++) step();
    check(tag, 32'(bus.o_init_done), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget && bus.o_busy; i++) step();
    check(tag, 32'(bus.o_busy), 32'd0);
  endtask

  task automatic push(input logic is_data, input logic [7:0] b, output logic accepted);
    bus.i_valid   = 1'b1;
    bus.i_is_data = is_data;
    bus.i_data    = b;
    accepted      = bus.o_ready;
    @(posedge clk);
    #1;
    bus.i_valid   = 1'b0;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_enable"},    32'(bus.o_enable),          32'd0);
    check({pfx, "_mosi"},      32'(bus.o_mosi_data),       32'd0);
    check({pfx, "_mode"},      32'(bus.o_data_mode),       32'd0);
    check({pfx, "_snd2"},      32'(bus.o_send_2nd_nibble), 32'd0);
    check({pfx, "_init_done"}, 32'(bus.o_init_done),       32'd0);
    check({pfx, "_error"},     32'(bus.o_error),           32'd0);
    check({pfx, "_busy"},      32'(bus.o_busy),            32'd1);
    check({pfx, "_ready"},     32'(bus.o_ready),           32'd1);
  endtask

  initial begin
    bus.i_valid   = 1'b0;
    bus.i_is_data = 1'b0;
    bus.i_data    = 8'h00;
    bus.i_busy    = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    check("with_pulse", 32'(bus.o_with_pulse), 32'd1);

    // Power-on init, with two characters pushed while it runs
    step();
    rst = 1'b0;
    rel = cyc;
    wait_enables(2, 6000, "init_first_enables");
    push(1'b1, 8'h48, acc); check("push_H", 32'(acc), 32'd1);
    push(1'b1, 8'h69, acc); check("push_i", 32'(acc), 32'd1);
    wait_init(20000, "init_done_timeout");
    check("init_count", 32'(rec.size() >= 9), 32'd1);
    if (rec.size() >= 9) begin
      check("first_enable_after_powerup", 32'(rec[0].cyc - rel >= 20), 32'd1);
      for (int i = 0; i < 9; i++) begin
        check($sformatf("init_code_%0d", i), 32'(rec[i].code), 32'(init_code[i]));
        check($sformatf("init_snd2_%0d", i), 32'(rec[i].snd2), 32'(init_snd2[i]));
        check($sformatf("init_mode_%0d", i), 32'(rec[i].mode), 32'd0);
      end
      check("gap_after_0x30", 32'(rec[1].cyc - rec[0].cyc >= 4100), 32'd1);
      check("gap_after_0x01", 32'(rec[7].cyc - rec[6].cyc >= 2000), 32'd1);
      check("done_after_last", 32'(rec[8].done), 32'd0);
    end
    wait_enables(11, 200, "held_chars_issued");
    if (rec.size() >= 11) begin
      check("H_code", 32'(rec[9].code), 32'h48);
      check("H_mode", 32'(rec[9].mode), 32'd1);
      check("H_snd2", 32'(rec[9].snd2), 32'd1);
      check("H_after_init", 32'(rec[9].done), 32'd1);
      check("i_code", 32'(rec[10].code), 32'h69);
      check("i_mode", 32'(rec[10].mode), 32'd1);
    end

    // Clear command gets a long delay; the following set-address does not
    wait_idle(200, "idle_before_clear");
    rec.delete();
    push(1'b0, 8'h01, acc); check("push_clear", 32'(acc), 32'd1);
    push(1'b0, 8'h80, acc); check("push_ddram", 32'(acc), 32'd1);
    push(1'b1, 8'h41, acc); check("push_A", 32'(acc), 32'd1);
    wait_enables(3, 5000, "clear_seq_issued");
    if (rec.size() >= 3) begin
      check("clear_code", 32'(rec[0].code), 32'h01);
      check("ddram_code", 32'(rec[1].code), 32'h80);
      check("A_code", 32'(rec[2].code), 32'h41);
      check("A_mode", 32'(rec[2].mode), 32'd1);
      check("clear_gap", 32'(rec[1].cyc - rec[0].cyc >= 2006), 32'd1);
      check("ddram_no_gap", 32'(rec[2].cyc - rec[1].cyc < 20), 32'd1);
    end

    // Backpressure: writer held busy; first byte sits in the output stage, 4 fill the FIFO
    wait_idle(200, "idle_before_burst");
    rec.delete();
    busy_mode = 2;
    step();
    push(1'b1, burst[0], acc); check("burst_acc_0", 32'(acc), 32'd1);
    repeat (4) step();
    for (int i = 1; i < 5; i++) begin
      push(1'b1, burst[i], acc);
      check($sformatf("burst_acc_%0d", i), 32'(acc), 32'd1);
    end
    check("ready_low_when_full", 32'(bus.o_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      push(1'b1, 8'h5A, acc);
      check($sformatf("burst_reject_%0d", i), 32'(acc), 32'd0);
    end
    check("no_enable_while_busy", 32'(rec.size()), 32'd0);
    busy_mode = 0;
    wait_enables(5, 500, "burst_issued");
    wait_idle(200, "idle_after_burst");
    check("burst_count", 32'(rec.size()), 32'd5);
    if (rec.size() >= 5)
      for (int i = 0; i < 5; i++)
        check($sformatf("burst_code_%0d", i), 32'(rec[i].code), 32'(burst[i]));
    check("ready_high_after_drain", 32'(bus.o_ready), 32'd1);

    // Ack timeout: writer never goes busy
    rst = 1'b1;
    busy_mode = 1;
    step();
    err_cyc = -1;
    rec.delete();
    rst = 1'b0;
    rel = cyc;
    wait_enables(1, 200, "timeout_first_enable");
    for (int i = 0; i < 40 && err_cyc < 0; i++) step();
    if (rec.size() >= 1)
      check("error_latency", 32'(err_cyc - rec[0].cyc), 32'd15);
    wait_init(20000, "timeout_init_done");
    check("timeout_init_count", 32'(rec.size()), 32'd9);
    check("error_sticky", 32'(bus.o_error), 32'd1);

    // Reset in the middle of a clear delay discards everything and restarts init
    busy_mode = 0;
    wait_idle(200, "idle_before_reset_test");
    rec.delete();
    push(1'b0, 8'h01, acc); check("push_clear2", 32'(acc), 32'd1);
    push(1'b1, 8'h55, acc); check("push_U", 32'(acc), 32'd1);
    wait_enables(1, 200, "clear2_issued");
    repeat (100) step();
    check("still_in_delay", 32'(rec.size()), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    step();
    rst = 1'b0;
    rel = cyc;
    rec.delete();
    wait_init(20000, "restart_init_done");
    wait_idle(200, "idle_after_restart");
    check("restart_count", 32'(rec.size()), 32'd9);
    if (rec.size() >= 1) begin
      check("restart_first_code", 32'(rec[0].code), 32'h30);
      check("restart_powerup", 32'(rec[0].cyc - rel >= 20), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
